// File: rtl/atm_pkg.sv
// Shared types and widths for the ATM transaction back end.
package atm_pkg;

    localparam int AMT_W  = 8;
    localparam int ACCT_W = 4;
    localparam int PIN_W  = 4;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_BAL   = 3'd0,
        OP_WDR   = 3'd1,
        OP_DEP   = 3'd2,
        OP_XFR   = 3'd3,
        OP_CHPIN = 3'd4,
        OP_VPIN  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_INSUF  = 2'd1,
        ST_OVF    = 2'd2,
        ST_REJECT = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/atm_txn_engine_if.sv
// Request/response bus between the session FSM (master) and the engine (slave).
interface atm_txn_engine_if;
    import atm_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ACCT_W-1:0] req_acct;
    logic [ACCT_W-1:0] req_dst_acct;
    logic [AMT_W-1:0]  req_amount;
    logic [PIN_W-1:0]  req_pin;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [AMT_W-1:0]  rsp_balance;

    modport master (
        output req_valid, req_op, req_acct, req_dst_acct, req_amount, req_pin,
        input  req_ready, rsp_valid, rsp_status, rsp_balance
    );

    modport slave (
        input  req_valid, req_op, req_acct, req_dst_acct, req_amount, req_pin,
        output req_ready, rsp_valid, rsp_status, rsp_balance
    );

endinterface

// File: rtl/atm_acct_store.sv
// Per-account balance and PIN registers with two async read ports and
// two balance write ports that commit on the same edge.
module atm_acct_store
    import atm_pkg::*;
#(
    parameter int                NUM_ACCOUNTS = 16,
    parameter logic [AMT_W-1:0]  INIT_BALANCE = 8'd100,
    parameter logic [PIN_W-1:0]  INIT_PIN     = 4'd0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ACCT_W-1:0] i_src_acct,
    input  logic [ACCT_W-1:0] i_dst_acct,
    output logic [AMT_W-1:0]  o_src_bal,
    output logic [AMT_W-1:0]  o_dst_bal,
    output logic [PIN_W-1:0]  o_src_pin,
    input  logic              i_we_a,
    input  logic [ACCT_W-1:0] i_wa_acct,
    input  logic [AMT_W-1:0]  i_wa_bal,
    input  logic              i_we_b,
    input  logic [ACCT_W-1:0] i_wb_acct,
    input  logic [AMT_W-1:0]  i_wb_bal,
    input  logic              i_pin_we,
    input  logic [ACCT_W-1:0] i_pin_acct,
    input  logic [PIN_W-1:0]  i_pin_data
);

    logic [AMT_W-1:0] r_bal [NUM_ACCOUNTS];
    logic [PIN_W-1:0] r_pin [NUM_ACCOUNTS];

    assign o_src_bal = r_bal[i_src_acct];
    assign o_dst_bal = r_bal[i_dst_acct];
    assign o_src_pin = r_pin[i_src_acct];

    // Balance array: both write ports land on the same edge (never the same account).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) r_bal[i] <= INIT_BALANCE;
        end else begin
            if (i_we_a) r_bal[i_wa_acct] <= i_wa_bal;
            if (i_we_b) r_bal[i_wb_acct] <= i_wb_bal;
        end
    end

    // PIN array: single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) r_pin[i] <= INIT_PIN;
        end else if (i_pin_we) begin
            r_pin[i_pin_acct] <= i_pin_data;
        end
    end

endmodule

// File: rtl/atm_txn_engine.sv
// ATM transaction engine: IDLE -> EXEC -> RESP, one request per three cycles.
// All store writes and the response registers update on the EXEC exit edge.
module atm_txn_engine
    import atm_pkg::*;
#(
    parameter int                NUM_ACCOUNTS = 16,
    parameter logic [AMT_W-1:0]  INIT_BALANCE = 8'd100,
    parameter logic [PIN_W-1:0]  INIT_PIN     = 4'd0
)(
    input  logic             clk,
    input  logic             rst_n,
    atm_txn_engine_if.slave  bus
);

    state_e            r_state, w_next;
    logic [OP_W-1:0]   r_op;
    logic [ACCT_W-1:0] r_acct, r_dst;
    logic [AMT_W-1:0]  r_amount;
    logic [PIN_W-1:0]  r_pin;
    status_e           r_status;
    logic [AMT_W-1:0]  r_rsp_bal;

    logic [AMT_W-1:0]  w_src_bal, w_dst_bal;
    logic [PIN_W-1:0]  w_src_pin;
    logic [AMT_W:0]    w_src_sum, w_dst_sum;
    logic              w_short;
    status_e           w_status;
    logic [AMT_W-1:0]  w_rsp_bal, w_new_src, w_new_dst;
    logic              w_we_src, w_we_dst, w_pin_we;

    atm_acct_store #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .INIT_BALANCE (INIT_BALANCE),
        .INIT_PIN     (INIT_PIN)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_src_acct (r_acct),
        .i_dst_acct (r_dst),
        .o_src_bal  (w_src_bal),
        .o_dst_bal  (w_dst_bal),
        .o_src_pin  (w_src_pin),
        .i_we_a     (w_we_src),
        .i_wa_acct  (r_acct),
        .i_wa_bal   (w_new_src),
        .i_we_b     (w_we_dst),
        .i_wb_acct  (r_dst),
        .i_wb_bal   (w_new_dst),
        .i_pin_we   (w_pin_we),
        .i_pin_acct (r_acct),
        .i_pin_data (r_pin)
    );

    // 9-bit sums expose the carry used for overflow detection.
    assign w_src_sum = {1'b0, w_src_bal} + {1'b0, r_amount};
    assign w_dst_sum = {1'b0, w_dst_bal} + {1'b0, r_amount};
    assign w_short   = (r_amount > w_src_bal);

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.rsp_valid   = (r_state == S_RESP);
    assign bus.rsp_status  = r_status;
    assign bus.rsp_balance = r_rsp_bal;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state, op evaluation and write strobes (strobes only asserted in EXEC).
    always_comb begin
        w_next    = r_state;
        w_status  = ST_OK;
        w_rsp_bal = '0;
        w_new_src = w_src_bal;
        w_new_dst = w_dst_bal;
        w_we_src  = 1'b0;
        w_we_dst  = 1'b0;
        w_pin_we  = 1'b0;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_RESP;
                case (r_op)
                    OP_BAL: w_rsp_bal = w_src_bal;
                    OP_WDR: begin
                        if (w_short) begin
                            w_status  = ST_INSUF;
                            w_rsp_bal = w_src_bal;
                        end else begin
                            w_we_src  = 1'b1;
                            w_new_src = w_src_bal - r_amount;
                            w_rsp_bal = w_new_src;
                        end
                    end
                    OP_DEP: begin
                        if (w_src_sum[AMT_W]) begin
                            w_status  = ST_OVF;
                            w_rsp_bal = w_src_bal;
                        end else begin
                            w_we_src  = 1'b1;
                            w_new_src = w_src_sum[AMT_W-1:0];
                            w_rsp_bal = w_new_src;
                        end
                    end
                    OP_XFR: begin
                        if (r_acct == r_dst) begin
                            w_status = ST_REJECT;
                        end else if (w_short) begin
                            w_status  = ST_INSUF;
                            w_rsp_bal = w_src_bal;
                        end else if (w_dst_sum[AMT_W]) begin
                            w_status  = ST_OVF;
                            w_rsp_bal = w_src_bal;
                        end else begin
                            w_we_src  = 1'b1;
                            w_we_dst  = 1'b1;
                            w_new_src = w_src_bal - r_amount;
                            w_new_dst = w_dst_sum[AMT_W-1:0];
                            w_rsp_bal = w_new_src;
                        end
                    end
                    OP_CHPIN: w_pin_we = 1'b1;
                    OP_VPIN:  w_status = (w_src_pin == r_pin) ? ST_OK : ST_REJECT;
                    default:  w_status = ST_REJECT;
                endcase
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture on the accepting edge; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_acct   <= '0;
            r_dst    <= '0;
            r_amount <= '0;
            r_pin    <= '0;
        end else if (r_state == S_IDLE && bus.req_valid) begin
            r_op     <= bus.req_op;
            r_acct   <= bus.req_acct;
            r_dst    <= bus.req_dst_acct;
            r_amount <= bus.req_amount;
            r_pin    <= bus.req_pin;
        end
    end

    // Response registers load on the EXEC exit edge and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status  <= ST_OK;
            r_rsp_bal <= '0;
        end else if (r_state == S_EXEC) begin
            r_status  <= w_status;
            r_rsp_bal <= w_rsp_bal;
        end
    end

endmodule

// File: doc/atm_txn_engine.md
# atm_txn_engine

Transaction back end for the ATM: consumes one operation request at a time from the session FSM, executes it against an on-chip account store (balance and PIN per account), and returns a status and resulting balance. It sits directly downstream of the session/menu FSM, which issues requests after authentication and operation selection. Every update is committed atomically on a single clock edge.

## Interface
Parameters:
- NUM_ACCOUNTS, 16: accounts in the store, indexed by a 4-bit account ID.
- INIT_BALANCE, 8'd100: balance of every account after reset.
- INIT_PIN, 4'd0: PIN of every account after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept; high only in IDLE.
- req_op  in  3  0 balance, 1 withdraw, 2 deposit, 3 transfer, 4 change PIN, 5 verify PIN, 6–7 invalid.
- req_acct  in  4  source/own account.
- req_dst_acct  in  4  transfer destination.
- req_amount  in  8  unsigned amount.
- req_pin  in  4  new PIN (op 4) or candidate PIN (op 5).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0 OK, 1 INSUFFICIENT, 2 OVERFLOW, 3 REJECT.
- rsp_balance  out  8  source-account balance after the op; 0 for PIN ops and REJECT.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture all req_* fields into registers and go to EXEC. Input changes after capture are ignored.
- EXEC: evaluate the op on the captured fields. Commit the balance/PIN writes and load rsp_status/rsp_balance on the exit edge. Go to RESP.
- RESP: rsp_valid=1, req_ready=0. Return to IDLE unconditionally. There is no response backpressure.
- Balance: status OK, no write.
- Withdraw: if amount > bal, INSUFFICIENT and no write; else bal−amount. Amount equal to the balance is OK and leaves 0.
- Deposit: 9-bit sum. If it exceeds 255, OVERFLOW and no write; else write. No saturation, ever.
- Transfer: src==dst gives REJECT. Otherwise check INSUFFICIENT on the source, then OVERFLOW on the destination. Both accounts are written on the same edge, or neither.
- Change PIN: write req_pin, status OK.
- Verify PIN: OK if equal to the stored PIN, else REJECT. Stored state is never modified.
- Ops 6–7: REJECT, no state change.
- Amount 0: always OK, balances unchanged.

## Timing
- Handshake at edge E0 → EXEC during E0..E1 → rsp_valid high E1..E2 → req_ready high again after E2.
- Request-to-response latency is 2 cycles. Maximum throughput is one request per 3 cycles.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0. All balances are INIT_BALANCE and all PINs are INIT_PIN.
- rsp_status/rsp_balance hold their last values after the pulse, until the next response.
- rst_n asserted in any state, including mid-EXEC, aborts the op with no partial write. The store and outputs return to reset values immediately, independent of clk.
- req_valid while not ready is ignored. The requester must hold it until accepted.

## Structure
- Package atm_pkg holds:
  - op codes, status codes and the state encoding;
  - AMT_W=8 and ACCT_W=4.
- Sub-module atm_acct_store holds the balance and PIN register arrays. It has:
  - two async read ports (src, dst);
  - two write ports for balances, committed on the same edge;
  - one PIN write port;
  - async active-low reset to the INIT values.
- The engine FSM and arithmetic live in atm_txn_engine.

## Test plan
- After reset, balance query on acct 3 → rsp_valid exactly 2 cycles after the handshake, status 0, balance 100, req_ready low for 2 cycles.
- Withdraw 100 from acct 3 → OK, balance 0. A second withdraw of 1 → INSUFFICIENT, balance 0.
- Deposit 155 to acct 5 → OK 255. Deposit 1 → OVERFLOW 255, unchanged.
- Transfer 40 from acct 1 to acct 2 → OK 60; balance on acct 2 reads 140. Transfer 1→1 → REJECT. Transfer 200 with source 60 → INSUFFICIENT, both unchanged.
- Change PIN on acct 7 to 9 → OK. Verify 9 → OK; verify 4 → REJECT. Op 6 → REJECT.
- Assert rst_n low during EXEC of a deposit → no rsp_valid, balance back to 100, req_ready=1 immediately.
